// File: rtl/varredura_display_pkg.sv
// rtl/varredura_display_pkg.sv - shared constants for the display scanner and its decoder
package varredura_display_pkg;

   // Common-anode display: a digit lights when its enable is driven low
   localparam logic DIGIT_ON  = 1'b0;
   localparam logic DIGIT_OFF = 1'b1;

   // Slot length for the board clock (50 MHz / 50000 = 1 kHz digit rate)
   localparam int DEFAULT_PRESCALE = 50000;

   // Width of one hex digit, shared with the hex-to-7-segment decoder
   localparam int NIBBLE_W = 4;

   typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/varredura_display_divisor_tick.sv
// rtl/varredura_display_divisor_tick.sv - parameterised prescaler with end-of-period tick
module divisor_tick #(
   parameter int PRESCALE = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   output logic [$clog2(PRESCALE)-1:0] count,
   output logic                        tick
);

   localparam int CW = $clog2(PRESCALE);

   // tick marks the last cycle of each period, so consumers act on the wrap
   assign tick = (count == CW'(PRESCALE - 1));

   // Free-running 0..PRESCALE-1 counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/varredura_display.sv
// rtl/varredura_display.sv - double-buffered multiplexed scanner for a common-anode hex display
module varredura_display
   import varredura_display_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [NIBBLE_W*DIGITS-1:0]   valor,
   input  logic                         lz_en,
   output logic [NIBBLE_W-1:0]          nibble,
   output logic [DIGITS-1:0]            digit_en,
   output logic                         frame_done
);

   localparam int IW = $clog2(DIGITS);
   localparam int PW = $clog2(PRESCALE);

   logic [PW-1:0]              presc;
   logic                       slot_end;
   logic [IW-1:0]              idx;
   logic [NIBBLE_W*DIGITS-1:0] shadow;
   logic [NIBBLE_W*DIGITS-1:0] disp;
   logic                       pending;
   logic                       frame_end;
   logic [DIGITS-1:0]          zero_from;
   logic                       zero_run;
   logic                       blanked;
   logic [DIGITS-1:0]          digit_sel;

   divisor_tick #(
      .PRESCALE(PRESCALE)
   ) u_divisor_tick (
      .clk  (clk),
      .rst  (rst),
      .count(presc),
      .tick (slot_end)
   );

   assign frame_end = slot_end && (idx == IW'(DIGITS - 1));

   // Advance to the next digit at the end of every slot, wrapping after the last
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx <= '0;
      end else if (slot_end) begin
         idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
   end

   // Double buffer: loads park in shadow and move to disp only on a frame boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow  <= '0;
         disp    <= '0;
         pending <= 1'b0;
      end else if (frame_end) begin
         if (load) begin
            disp   <= valor;
            shadow <= valor;
         end else if (pending) begin
            disp <= shadow;
         end
         pending <= 1'b0;
      end else if (load) begin
         shadow  <= valor;
         pending <= 1'b1;
      end
   end

   // zero_from[i] is set when nibbles i..DIGITS-1 of disp are all zero
   always_comb begin
      zero_from = '0;
      zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_run     = zero_run && (disp[NIBBLE_W*i +: NIBBLE_W] == '0);
         zero_from[i] = zero_run;
      end
   end

   // Digit 0 is never blanked so a zero value still shows one "0"
   assign blanked = lz_en && (idx != '0) && zero_from[idx];

   // One-hot-low enable for the current digit
   always_comb begin
      digit_sel      = {DIGITS{DIGIT_OFF}};
      digit_sel[idx] = DIGIT_ON;
   end

   // Registered outputs; presc==0 gives a dead cycle between digits against ghosting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nibble     <= '0;
         digit_en   <= {DIGITS{DIGIT_OFF}};
         frame_done <= 1'b0;
      end else begin
         nibble     <= disp[NIBBLE_W*idx +: NIBBLE_W];
         digit_en   <= ((presc == '0) || blanked) ? {DIGITS{DIGIT_OFF}} : digit_sel;
         frame_done <= frame_end;
      end
   end

endmodule

// File: tb/tb_varredura_display.sv
// tb/tb_varredura_display.sv - directed self-checking bench for varredura_display (DIGITS=4, PRESCALE=4)
module tb_varredura_display;

   logic        clk;
   logic        rst;
   logic        load;
   logic [15:0] valor;
   logic        lz_en;
   logic [3:0]  nibble;
   logic [3:0]  digit_en;
   logic        frame_done;

   int checks;
   int errors;
   int cyc;

   varredura_display #(
      .DIGITS  (4),
      .PRESCALE(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .valor     (valor),
      .lz_en     (lz_en),
      .nibble    (nibble),
      .digit_en  (digit_en),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected enables for the scanner state m cycles after reset release
   function automatic logic [3:0] exp_en(input int m, input logic [15:0] d, input logic lz);
      int          p;
      int          i;
      logic [15:0] hi;
      p  = m % 4;
      i  = (m / 4) % 4;
      hi = d >> (4 * i);
      if (p == 0) return 4'hF;
      if (lz && (i > 0) && (hi == 16'h0000)) return 4'hF;
      return ~(4'b0001 << i);
   endfunction

   function automatic logic [3:0] exp_nib(input int m, input logic [15:0] d);
      logic [15:0] t;
      t = d >> (4 * ((m / 4) % 4));
      return t[3:0];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      load = 1'b0;
      cyc++;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      load  = 1'b0;
      valor = 16'h0000;
      lz_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      if (digit_en !== 4'hF) begin errors++; $display("FAIL reset_digit_en got %b want %b", digit_en, 4'hF); end
      if (nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble got %h want %h", nibble, 4'h0); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
      checks += 3;
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_scan();
      for (int k = 0; k < 32; k++) begin
         step();
         if (digit_en !== exp_en(cyc - 1, 16'h0000, 1'b0)) begin errors++; $display("FAIL scan_digit_en cyc=%0d got %b want %b", cyc, digit_en, exp_en(cyc - 1, 16'h0000, 1'b0)); end
         if (nibble !== 4'h0) begin errors++; $display("FAIL scan_nibble cyc=%0d got %h want 0", cyc, nibble); end
         if (frame_done !== 1'((cyc % 16) == 0)) begin errors++; $display("FAIL scan_frame_done cyc=%0d got %b want %b", cyc, frame_done, (cyc % 16) == 0); end
         checks += 3;
      end
   endtask

   task automatic test_load_swap();
      logic [15:0] d;
      for (int k = 0; k < 32; k++) begin
         d = (k < 16) ? 16'h0000 : 16'h1A2F;
         if (k == 5) begin load = 1'b1; valor = 16'h1A2F; end
         step();
         if (digit_en !== exp_en(cyc - 1, d, 1'b0)) begin errors++; $display("FAIL swap_digit_en cyc=%0d got %b want %b", cyc, digit_en, exp_en(cyc - 1, d, 1'b0)); end
         if (nibble !== exp_nib(cyc - 1, d)) begin errors++; $display("FAIL swap_nibble cyc=%0d got %h want %h", cyc, nibble, exp_nib(cyc - 1, d)); end
         if (frame_done !== 1'((cyc % 16) == 0)) begin errors++; $display("FAIL swap_frame_done cyc=%0d got %b want %b", cyc, frame_done, (cyc % 16) == 0); end
         checks += 3;
      end
   endtask

   task automatic test_last_load_wins();
      logic [15:0] d;
      for (int k = 0; k < 32; k++) begin
         d = (k < 16) ? 16'h1A2F : 16'h2222;
         if (k == 2) begin load = 1'b1; valor = 16'h1111; end
         if (k == 9) begin load = 1'b1; valor = 16'h2222; end
         step();
         if (digit_en !== exp_en(cyc - 1, d, 1'b0)) begin errors++; $display("FAIL lastload_digit_en cyc=%0d got %b want %b", cyc, digit_en, exp_en(cyc - 1, d, 1'b0)); end
         if (nibble !== exp_nib(cyc - 1, d)) begin errors++; $display("FAIL lastload_nibble cyc=%0d got %h want %h", cyc, nibble, exp_nib(cyc - 1, d)); end
         checks += 2;
      end
   endtask

   task automatic test_boundary_load();
      logic [15:0] d;
      for (int k = 0; k < 32; k++) begin
         d = (k < 16) ? 16'h2222 : 16'h00C3;
         if (k == 4) begin load = 1'b1; valor = 16'h1111; end
         if (k == 15) begin load = 1'b1; valor = 16'h00C3; end
         step();
         if (digit_en !== exp_en(cyc - 1, d, 1'b0)) begin errors++; $display("FAIL boundary_digit_en cyc=%0d got %b want %b", cyc, digit_en, exp_en(cyc - 1, d, 1'b0)); end
         if (nibble !== exp_nib(cyc - 1, d)) begin errors++; $display("FAIL boundary_nibble cyc=%0d got %h want %h", cyc, nibble, exp_nib(cyc - 1, d)); end
         checks += 2;
      end
   endtask

   task automatic test_leading_zeros();
      logic [15:0] d;
      lz_en = 1'b1;
      for (int k = 0; k < 48; k++) begin
         d = (k < 16) ? 16'h00C3 : (k < 32) ? 16'h0000 : 16'h0C03;
         if (k == 7) begin load = 1'b1; valor = 16'h0000; end
         if (k == 19) begin load = 1'b1; valor = 16'h0C03; end
         step();
         if (digit_en !== exp_en(cyc - 1, d, 1'b1)) begin errors++; $display("FAIL lz_digit_en cyc=%0d got %b want %b", cyc, digit_en, exp_en(cyc - 1, d, 1'b1)); end
         if (nibble !== exp_nib(cyc - 1, d)) begin errors++; $display("FAIL lz_nibble cyc=%0d got %h want %h", cyc, nibble, exp_nib(cyc - 1, d)); end
         checks += 2;
      end
      lz_en = 1'b0;
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 9; k++) begin
         if (k == 3) begin load = 1'b1; valor = 16'h5555; end
         step();
      end
      #2;
      rst = 1'b1;
      #1;
      if (digit_en !== 4'hF) begin errors++; $display("FAIL async_digit_en got %b want %b", digit_en, 4'hF); end
      if (nibble !== 4'h0) begin errors++; $display("FAIL async_nibble got %h want 0", nibble); end
      if (frame_done !== 1'b0) begin errors++; $display("FAIL async_frame_done got %b want 0", frame_done); end
      checks += 3;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      for (int k = 0; k < 32; k++) begin
         step();
         if (digit_en !== exp_en(cyc - 1, 16'h0000, 1'b0)) begin errors++; $display("FAIL rescan_digit_en cyc=%0d got %b want %b", cyc, digit_en, exp_en(cyc - 1, 16'h0000, 1'b0)); end
         if (nibble !== 4'h0) begin errors++; $display("FAIL rescan_nibble cyc=%0d got %h want 0", cyc, nibble); end
         if (frame_done !== 1'((cyc % 16) == 0)) begin errors++; $display("FAIL rescan_frame_done cyc=%0d got %b want %b", cyc, frame_done, (cyc % 16) == 0); end
         checks += 3;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      test_reset();
      test_scan();
      test_load_swap();
      test_last_load_wins();
      test_boundary_load();
      test_leading_zeros();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/varredura_display.md
Name: varredura_display

Overview:
Time-multiplexed scanner that sits directly upstream of the hex-to-7-segment decoder. It double-buffers a DIGITS-nibble value (e.g. a register-file read port or PC), selects one nibble per scan slot and drives it to the decoder's 4-bit selector. It also drives active-low digit enables for a common-anode multi-digit display. Optional leading-zero blanking; new values swap in only at frame boundaries, so a frame never shows a mix of old and new nibbles.

Parameters:
DIGITS, 8, number of display digits / nibbles (2..8)
PRESCALE, 50000, clock cycles per digit slot (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load  in  1  one-cycle strobe: capture valor into shadow buffer
valor  in  4*DIGITS  value to display; nibble i = valor[4i+3:4i], digit 0 = least significant
lz_en  in  1  1 = blank leading zeros
nibble  out  4  nibble for current digit, to decoder selector
digit_en  out  DIGITS  active-low digit enables, one-hot-low or all-high
frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clock: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: presc=0, idx=0, shadow=0, disp=0, pending=0, nibble=0, digit_en=all 1s (all off), frame_done=0. Reset mid-frame aborts the scan immediately and restarts at digit 0.
- Prescaler: presc counts 0..PRESCALE-1 and wraps. slot_end = (presc==PRESCALE-1).
- Digit index: on slot_end, idx <= (idx==DIGITS-1) ? 0 : idx+1.
- Frame boundary: slot_end && idx==DIGITS-1.
- Load when not at a frame boundary: shadow <= valor, pending <= 1. A repeated load while pending overwrites shadow; the last load wins.
- At a frame boundary with no load: if pending, disp <= shadow and pending <= 0; otherwise disp is unchanged.
- At a frame boundary with a simultaneous load: disp <= valor (bypass), shadow <= valor, pending <= 0.
- Outputs are registered and updated every cycle from the current idx/disp, so there is 1 cycle of latency after an idx or disp change.
  - nibble <= disp[4*idx +: 4]
  - digit_en <= ~(1 << idx), except forced all 1s when presc==0 (1-cycle dead time against ghosting) or when the digit is blanked.
- Blanking: digit i (i>0) is blanked when lz_en=1 and disp nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked, so the value 0 shows a single "0". While blanked, nibble still carries the value 0.
- frame_done <= 1 for exactly the cycle following a frame boundary; 0 otherwise.
- Timing: frame period = DIGITS*PRESCALE cycles. Max latency from load to display is one frame + 1 cycle.

Decomposition:
- Shared package constants: DIGIT_ON=0 / DIGIT_OFF=1 levels, default PRESCALE for the board clock, and NIBBLE_W=4 (shared with the decoder).
- One natural sub-module: `divisor_tick`. It is the parameterised prescaler producing the presc count and the slot_end pulse, and is reusable by the clock-divider and debounce blocks.
- The digit index, double buffer and output registers stay in the top module.

Test Plan (DIGITS=4, PRESCALE=4):
- Reset scan:
  - Deassert rst with no load -> digit_en sequence 1111 then 1110 x3 cycles, 1111 then 1101 x3, ..., digit 3.
  - nibble=0 throughout; frame_done pulses every 16 cycles.
- Load and swap:
  - load valor=16'h1A2F mid-frame -> disp stays 0 until the frame boundary.
  - Next frame: nibble = F, 2, A, 1 for digits 0..3; pending clears.
- Last load wins: load 16'h1111, then 16'h2222 in the same frame -> next frame shows 2,2,2,2; 1111 never appears.
- Load on boundary cycle: load 16'h00C3 exactly when slot_end && idx==3 -> the frame starting one cycle later shows 3,C,0,0.
- Leading zeros:
  - lz_en=1, value 16'h00C3 -> digits 2,3 keep digit_en all 1s in their slots; digits 0,1 enabled.
  - Value 16'h0000 -> only digit 0 is lit, showing 0.
- Async reset mid-operation: assert rst at idx=2 between clock edges -> digit_en=1111, nibble=0 immediately; disp/shadow cleared; after release the scan restarts at digit 0.
